scope_trace_renderer: RTL and testbench

- Single-clock, parametrised successor of the 1-bit frame-bitmap HDMI controller for the oscilloscope display.
- Stores one row value per column per channel in a ping-pong column buffer, instead of a full-frame bitmap, so no clean pass is needed.
- Renders up to 4 coloured traces with vertical interpolation between adjacent columns, over a graticule.
- Sits between the sample/decimation stage and the HDMI encoder (VDE/HSYNC/VSYNC/RGB).

---
 rtl/scope_trace_renderer.sv | 210 +++++++++++++++++++++
 tb/tb_scope_trace_renderer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/scope_trace_renderer.sv
// Oscilloscope trace renderer for the HDMI path. Each channel keeps one row
// per column in a ping-pong buffer. Adjacent columns are joined by vertical
// spans and drawn over a graticule, with VDE/HSYNC/VSYNC timing alongside.

// Per-channel lane. It maps a sample to a row, stores it in the ping-pong
// buffer, reads the front column back and tests the current line against the
// span formed with the previous column.
module scope_trace_lane #(
   parameter int VAL_RES = 16,
   parameter int V_ACT   = 480,
   parameter int H_ACT   = 640,
   parameter int AW      = 11,
   parameter int RW      = 9,
   parameter int YW      = 10
) (
   input  logic               clk,
   input  logic               ld,
   input  logic [VAL_RES-1:0] val,
   input  logic               wr_en,
   input  logic [AW-1:0]      wr_addr,
   input  logic [AW-1:0]      rd_addr,
   input  logic               col0,
   input  logic [YW-1:0]      y_s1,
   output logic               hit
);
   localparam int PW = VAL_RES + RW;

   logic [VAL_RES-1:0] inv;
   logic [PW-1:0]      prod;
   logic [RW-1:0]      row_q, cur, prv, p, lo, hi;
   logic [RW-1:0]      mem [2*H_ACT];

   // Inverting the sample puts full scale at row 0. The shift truncates, so
   // val=0 lands on row V_ACT-2 and the bottom graticule line stays visible.
   assign inv  = ~val;
   assign prod = PW'(inv) * PW'(V_ACT-1);

   // Register the row once on the handshake; the buffer write follows a cycle later.
   always_ff @(posedge clk) begin
      if (ld) row_q <= RW'(prod >> VAL_RES);
   end

   // Buffer write, front-bank read, and the previous-column history.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= row_q;
      cur <= mem[rd_addr];
      prv <= cur;
   end

   // Column 0 has no left neighbour, so its span collapses to its own row.
   always_comb begin
      p   = col0 ? cur : prv;
      lo  = (p < cur) ? p : cur;
      hi  = (p < cur) ? cur : p;
      hit = (YW'(lo) <= y_s1) && (y_s1 <= YW'(hi));
   end
endmodule

module scope_trace_renderer #(
   parameter int CH       = 2,
   parameter int VAL_RES  = 16,
   parameter int H_ACT    = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACT    = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int GRID_X   = 64,
   parameter int GRID_Y   = 60,
   parameter bit SYNC_POL = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [CH*VAL_RES-1:0] s_data,
   input  logic [CH-1:0]         ch_en,
   output logic                  vde,
   output logic                  hsync,
   output logic                  vsync,
   output logic [23:0]           pixel,
   output logic                  swap
);
   localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
   localparam int XW  = $clog2(H_TOT);
   localparam int YW  = $clog2(V_TOT);
   localparam int RW  = $clog2(V_ACT);
   localparam int CW  = $clog2(H_ACT);
   localparam int AW  = $clog2(2*H_ACT);
   localparam int GXW = $clog2(GRID_X);
   localparam int GYW = $clog2(GRID_Y);
   localparam logic [3:0][23:0] CH_COL = {24'hFF00FF, 24'h00FFFF, 24'hFFFF00, 24'h00FF00};
   localparam logic [23:0] GRID_COL = 24'h404040;

   typedef enum logic {CAPTURE, FULL} wst_t;

   wst_t           wst;
   logic [XW-1:0]  x;
   logic [YW-1:0]  y;
   logic [GXW-1:0] gx;
   logic [GYW-1:0] gy;
   logic [CW-1:0]  wr_col;
   logic [AW-1:0]  wr_addr_q, rd_addr;
   logic           bsel, front_valid, wr_en_q, take, act, swap_pt, x_last;
   logic [2:1]     vld_pipe;
   logic           hs_s1, vs_s1, grid_s1, col0_s1;
   logic [YW-1:0]  y_s1;
   logic [CH-1:0]  hit;
   logic [23:0]    pix_nx;

   assign x_last  = int'(x) == H_TOT-1;
   assign act     = (int'(x) < H_ACT) && (int'(y) < V_ACT);
   assign take    = s_valid & s_ready;
   assign swap_pt = (x == '0) && (int'(y) == V_ACT+V_FP);
   assign rd_addr = (bsel ? AW'(H_ACT) : '0) + (act ? AW'(x) : '0);

   // Raster counters, plus graticule phase counters that avoid a modulo.
   always_ff @(posedge clk) begin
      if (!rst) begin
         x <= '0; y <= '0; gx <= '0; gy <= '0;
      end else begin
         x  <= x_last ? '0 : x + XW'(1);
         gx <= (x_last || int'(gx) == GRID_X-1) ? '0 : gx + GXW'(1);
         if (x_last) begin
            y  <= (int'(y) == V_TOT-1) ? '0 : y + YW'(1);
            gy <= (int'(y) == V_TOT-1 || int'(gy) == GRID_Y-1) ? '0 : gy + GYW'(1);
         end
      end
   end

   // Capture FSM: fill the back bank, then wait for vsync to flip banks.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wst <= CAPTURE; s_ready <= 1'b0; wr_col <= '0; bsel <= 1'b0;
         front_valid <= 1'b0; swap <= 1'b0; wr_en_q <= 1'b0; wr_addr_q <= '0;
      end else begin
         swap      <= 1'b0;
         wr_en_q   <= take;
         wr_addr_q <= (bsel ? '0 : AW'(H_ACT)) + AW'(wr_col);
         case (wst)
            CAPTURE: begin
               s_ready <= 1'b1;
               if (take) begin
                  if (int'(wr_col) == H_ACT-1) begin
                     wst     <= FULL;
                     s_ready <= 1'b0;
                  end else begin
                     wr_col <= wr_col + CW'(1);
                  end
               end
            end
            FULL: begin
               if (swap_pt) begin
                  bsel        <= ~bsel;
                  front_valid <= 1'b1;
                  swap        <= 1'b1;
                  wr_col      <= '0;
                  wst         <= CAPTURE;
                  s_ready     <= 1'b1;
               end
            end
         endcase
      end
   end

   for (genvar k = 0; k < CH; k++) begin : g_lane
      scope_trace_lane #(
         .VAL_RES(VAL_RES), .V_ACT(V_ACT), .H_ACT(H_ACT),
         .AW(AW), .RW(RW), .YW(YW)
      ) u_lane (
         .clk(clk), .ld(take), .val(s_data[k*VAL_RES +: VAL_RES]),
         .wr_en(wr_en_q), .wr_addr(wr_addr_q), .rd_addr(rd_addr),
         .col0(col0_s1), .y_s1(y_s1), .hit(hit[k])
      );
   end

   // Trace colour beats graticule; among traces the lowest channel wins.
   always_comb begin
      pix_nx = 24'h000000;
      if (vld_pipe[1]) begin
         if (grid_s1) pix_nx = GRID_COL;
         for (int k = CH-1; k >= 0; k--)
            if (front_valid && ch_en[k] && hit[k]) pix_nx = CH_COL[k];
      end
   end

   // Stage 1 delays the raster flags to match the buffer read; stage 2 drives the outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_pipe <= '0; hs_s1 <= 1'b0; vs_s1 <= 1'b0; grid_s1 <= 1'b0;
         col0_s1 <= 1'b0; y_s1 <= '0;
         hsync <= ~SYNC_POL; vsync <= ~SYNC_POL; pixel <= '0;
      end else begin
         vld_pipe <= {vld_pipe[1], act};
         hs_s1    <= (int'(x) >= H_ACT+H_FP) && (int'(x) < H_ACT+H_FP+H_SYNC);
         vs_s1    <= (int'(y) >= V_ACT+V_FP) && (int'(y) < V_ACT+V_FP+V_SYNC);
         grid_s1  <= (gx == '0) || (gy == '0) || (int'(x) == H_ACT-1) || (int'(y) == V_ACT-1);
         col0_s1  <= (x == '0);
         y_s1     <= y;
         hsync    <= hs_s1 ? SYNC_POL : ~SYNC_POL;
         vsync    <= vs_s1 ? SYNC_POL : ~SYNC_POL;
         pixel    <= pix_nx;
      end
   end

   assign vde = vld_pipe[2];
endmodule

// File: tb/tb_scope_trace_renderer.sv
// Directed bench for scope_trace_renderer on a shrunken raster:
// 16x12 active, 24x16 total, graticule pitch 4x3.
module tb_scope_trace_renderer;
   localparam int TH = 24;
   localparam int TV = 16;
   localparam logic [23:0] G = 24'h00FF00, Y = 24'hFFFF00, GR = 24'h404040, K = 24'h000000;

   logic        clk = 1'b0;
   logic        rst, s_valid, s_ready, vde, hsync, vsync, swap;
   logic [31:0] s_data;
   logic [1:0]  ch_en;
   logic [23:0] pixel;

   int ntot = 0, npass = 0;
   int tx, ty, p1x, p1y, p2x, p2y;
   logic v1, v2;

   always #5 clk = ~clk;

   scope_trace_renderer #(
      .CH(2), .VAL_RES(16), .H_ACT(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_ACT(12), .V_FP(1), .V_SYNC(2), .V_BP(1), .GRID_X(4), .GRID_Y(3), .SYNC_POL(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .ch_en(ch_en), .vde(vde), .hsync(hsync), .vsync(vsync), .pixel(pixel), .swap(swap)
   );

   // Reference raster position; (p2x,p2y) is the position now on the outputs.
   always @(posedge clk) begin
      if (!rst) begin
         tx <= 0; ty <= 0; v1 <= 1'b0; v2 <= 1'b0;
      end else begin
         p1x <= tx; p1y <= ty; v1 <= 1'b1;
         p2x <= p1x; p2y <= p1y; v2 <= v1;
         tx <= (tx == TH-1) ? 0 : tx + 1;
         if (tx == TH-1) ty <= (ty == TV-1) ? 0 : ty + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ntot++;
      if (got === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Advance to the next time output position (x,y) is on the pins.
   task automatic at_px(input int x, input int y);
      int g = 0;
      do begin @(negedge clk); g++; end
      while (!(v2 && p2x == x && p2y == y) && g < 2000);
      chk("pos_found", (v2 && p2x == x && p2y == y), 1);
   endtask

   task automatic px(input string tag, input int x, input int y, input logic [23:0] exp);
      at_px(x, y);
      chk(tag, pixel, exp);
   endtask

   function automatic logic [31:0] beat(input int mode, input int i);
      logic [15:0] r;
      r = 16'hFFFF - 16'(i * 4096);
      case (mode)
         0:       return {16'h0000, 16'hFFFF};
         1:       return {16'h8000, r};
         2:       return {16'h8000, 16'h8000};
         default: return 32'h0;
      endcase
   endfunction

   task automatic send(input int n, input int mode);
      int i = 0, g = 0;
      logic rdy;
      while (i < n && g < 5000) begin
         @(negedge clk);
         s_valid = 1'b1; s_data = beat(mode, i); rdy = s_ready;
         @(posedge clk);
         if (rdy) i++;
         g++;
      end
      @(negedge clk);
      s_valid = 1'b0;
      chk("send_count", i, n);
   endtask

   task automatic wait_swap();
      int g = 0;
      do begin @(negedge clk); g++; end while (!swap && g < 1000);
      chk("swap_seen", swap, 1);
      chk("swap_x", tx, 1);
      chk("swap_y", ty, 13);
   endtask

   initial begin
      int n;
      rst = 1'b0; s_valid = 1'b0; s_data = '0; ch_en = 2'b11;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_vde", vde, 0);    chk("rst_pixel", pixel, 0);
      chk("rst_hsync", hsync, 0); chk("rst_vsync", vsync, 0);
      chk("rst_ready", s_ready, 0); chk("rst_swap", swap, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("rel_ready", s_ready, 1);
      chk("vde_lat1", vde, 0);
      @(negedge clk);
      chk("vde_lat2", vde, 1);

      n = 0;
      repeat (TH) begin @(negedge clk); if (hsync) n++; end
      chk("hsync_width", n, 4);
      n = 0;
      repeat (TH*TV) begin @(negedge clk); if (vsync) n++; end
      chk("vsync_width", n, 2*TH);

      // Empty display: graticule only
      px("grid_0_0", 0, 0, GR);
      at_px(17, 0); chk("hsync_pre", hsync, 0);
      at_px(18, 0); chk("hsync_on", hsync, 1);
      px("blank_1_1", 1, 1, K);
      px("grid_4_1", 4, 1, GR);
      px("grid_15_1", 15, 1, GR);
      px("grid_1_3", 1, 3, GR);
      px("grid_1_11", 1, 11, GR);

      // Full capture: ch0 full scale, ch1 zero
      send(16, 0);
      chk("full_ready", s_ready, 0);
      wait_swap();
      chk("swap_ready", s_ready, 1);
      for (int x = 0; x < 16; x++) px("row0_green", x, 0, G);
      for (int x = 0; x < 16; x++) px("row10_yellow", x, 10, Y);
      px("row11_grid", 3, 11, GR);
      px("mid_blank", 1, 5, K);

      // Ramp on ch0, ch1 disabled
      ch_en = 2'b01;
      send(16, 1);
      wait_swap();
      px("r_0_0", 0, 0, G);    px("r_3_0", 3, 0, GR);
      px("r_0_1", 0, 1, GR);   px("r_1_1", 1, 1, K);   px("r_3_1", 3, 1, G);
      px("r_3_2", 3, 2, G);
      px("r_3_3", 3, 3, GR);   px("r_6_3", 6, 3, G);
      px("r_6_4", 6, 4, G);
      px("r_1_5", 1, 5, K);    px("r_2_5", 2, 5, K);   px("r_6_5", 6, 5, K);
      px("r_14_8", 14, 8, G);  px("r_15_8", 15, 8, GR);
      px("r_14_9", 14, 9, G);  px("r_15_9", 15, 9, G);
      px("r_14_10", 14, 10, K); px("r_15_10", 15, 10, G);

      // Overlapping traces on row 5
      ch_en = 2'b11;
      send(16, 2);
      wait_swap();
      px("ovl_1_5", 1, 5, G);
      px("ovl_7_5", 7, 5, G);
      ch_en = 2'b10;
      px("ovl_ch1", 2, 5, Y);
      ch_en = 2'b11;

      // Partial capture must not swap
      send(6, 3);
      chk("part_ready", s_ready, 1);
      n = 0;
      repeat (TH*TV + 16) begin @(negedge clk); if (swap) n++; end
      chk("part_noswap", n, 0);
      px("part_old5", 1, 5, G);
      px("part_old10", 1, 10, K);
      send(10, 3);
      wait_swap();
      px("cmp_1_5", 1, 5, K);
      px("cmp_1_10", 1, 10, G);
      px("cmp_15_10", 15, 10, G);

      // One-cycle reset mid-line
      at_px(8, 2);
      rst = 1'b0;
      @(negedge clk);
      chk("mrst_vde", vde, 0);    chk("mrst_pixel", pixel, 0);
      chk("mrst_hsync", hsync, 0); chk("mrst_vsync", vsync, 0);
      chk("mrst_ready", s_ready, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_rel_ready", s_ready, 1);
      px("mrst_grid", 0, 10, GR);
      px("mrst_blank", 1, 10, K);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
